// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Arbitrates two write-back requesters (A = ALU, B = load unit) onto a
//   single register-file write port, and keeps a 32-entry busy scoreboard
//   used for source-operand hazard queries.
//
//   Ports
//     clk, rst              clock, asynchronous active-high reset
//     a_valid/a_rd/a_data   requester A write (held until a_ready)
//     a_ready               A granted this cycle (combinational)
//     b_valid/b_rd/b_data   requester B write (held until b_ready)
//     b_ready               B granted this cycle (combinational)
//     iss_valid, iss_rd     issuing instruction marks iss_rd busy
//     rs1, rs2              source registers queried for hazards
//     rs1_busy, rs2_busy    queried register has a write pending
//     rf_we/rf_rd/rf_wdata  registered register-file write port
//
//   Configuration
//     WB_ARB_RR_EN  defined   : round-robin on contention
//                   undefined : fixed priority, A always wins
module regfile_wb_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    output logic            b_ready,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata
);

    logic            grant_a;
    logic            grant_b;
    logic            xfer;
    logic [4:0]      xfer_rd;
    logic [XLEN-1:0] xfer_data;
    logic [31:0]     busy;
    logic [31:0]     busy_nxt;

`ifdef WB_ARB_RR_EN
    // prefer_b is set after A wins and cleared after B wins, so the
    // requester that was not granted most recently wins the next tie.
    logic prefer_b;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst) begin
            if (a_valid && b_valid) begin
                grant_a = !prefer_b;
                grant_b = prefer_b;
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prefer_b <= 1'b0;
        else if (grant_a)
            prefer_b <= 1'b1;
        else if (grant_b)
            prefer_b <= 1'b0;
    end
`else
    always_comb begin
        grant_a = !rst && a_valid;
        grant_b = !rst && b_valid && !a_valid;
    end
`endif

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign xfer      = grant_a || grant_b;
    assign xfer_rd   = grant_b ? b_rd   : a_rd;
    assign xfer_data = grant_b ? b_data : a_data;

    // Output stage drains every cycle; rd==0 writes still update the
    // address/data registers but never pulse rf_we.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_rd    <= 5'd0;
            rf_wdata <= '0;
        end else begin
            rf_we <= xfer && (xfer_rd != 5'd0);
            if (xfer) begin
                rf_rd    <= xfer_rd;
                rf_wdata <= xfer_data;
            end
        end
    end

    // Clear first, then set, so an issue to the register being written
    // back in the same cycle leaves it busy.
    always_comb begin
        busy_nxt = busy;
        if (xfer)
            busy_nxt[xfer_rd] = 1'b0;
        if (iss_valid)
            busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    // The write sitting in the output stage has already cleared its busy
    // bit but is not yet in the register file, so it still counts.
    assign rs1_busy = (rs1 != 5'd0) && (busy[rs1] || (rf_we && (rf_rd == rs1)));
    assign rs2_busy = (rs2 != 5'd0) && (busy[rs2] || (rf_we && (rf_rd == rs2)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, iss_valid;
    logic [4:0]  a_rd, b_rd, iss_rd, rs1, rs2;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, rs1_busy, rs2_busy, rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    int n_vec = 0;
    int n_err = 0;

    regfile_wb_arbiter #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit        busy_m [32];
    bit        m_we = 1'b0;
    bit [4:0]  m_rd = '0;
    bit [31:0] m_wd = '0;
    bit        last_b = 1'b1;   // "B won last" => A preferred on the next tie

    // returns {grant_b, grant_a}
    function automatic logic [1:0] model_grant(input logic av, input logic bv, input bit lb);
        if (av && bv) begin
`ifdef WB_ARB_RR_EN
            return lb ? 2'b01 : 2'b10;
`else
            return 2'b01;
`endif
        end
        return {bv, av};
    endfunction

    function automatic bit rs_exp(input logic [4:0] rs);
        return (rs != 0) && (busy_m[rs] || (m_we && m_rd == rs));
    endfunction

    logic [1:0]  m_g;
    logic [4:0]  m_xrd;
    logic [31:0] m_xd;
    assign m_g   = model_grant(a_valid, b_valid, last_b);
    assign m_xrd = m_g[1] ? b_rd : a_rd;
    assign m_xd  = m_g[1] ? b_data : a_data;

    always @(posedge clk) begin
        if (rst) begin
            m_we   <= 1'b0;
            m_rd   <= '0;
            m_wd   <= '0;
            last_b <= 1'b1;
            for (int i = 0; i < 32; i++) busy_m[i] <= 1'b0;
        end else begin
            m_we <= 1'b0;
            if (m_g != 2'b00) begin
                m_we   <= (m_xrd != 0);
                m_rd   <= m_xrd;
                m_wd   <= m_xd;
                last_b <= m_g[1];
                if (m_xrd != 0) busy_m[m_xrd] <= 1'b0;
            end
            if (iss_valid && iss_rd != 0) busy_m[iss_rd] <= 1'b1;
        end
    end

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            chk("a_ready", {31'd0, a_ready}, 0);
            chk("b_ready", {31'd0, b_ready}, 0);
            chk("rf_we", {31'd0, rf_we}, 0);
            chk("rf_rd", {27'd0, rf_rd}, 0);
            chk("rf_wdata", rf_wdata, 0);
            chk("rs1_busy", {31'd0, rs1_busy}, 0);
            chk("rs2_busy", {31'd0, rs2_busy}, 0);
        end else begin
            chk("a_ready", {31'd0, a_ready}, {31'd0, m_g[0]});
            chk("b_ready", {31'd0, b_ready}, {31'd0, m_g[1]});
            chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
            chk("rf_rd", {27'd0, rf_rd}, {27'd0, m_rd});
            chk("rf_wdata", rf_wdata, m_wd);
            chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, rs_exp(rs1)});
            chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, rs_exp(rs2)});
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt();          // move to just after the next rising edge
        @(posedge clk);
        #1;
    endtask

    task automatic mid();          // move to just after the next falling edge
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0; iss_valid = 0;
        a_rd = 0; b_rd = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
        a_data = 0; b_data = 0;
    endtask

    task automatic do_reset();
        nxt();
        rst = 1;
        idle_inputs();
        nxt();
        rst = 0;
    endtask

    logic a_took, b_took;
    logic exp_a;

    initial begin
        rst = 1;
        idle_inputs();
        a_valid = 1;
        rs1 = 5;

        // reset behaviour with a pending request
        mid();
        chk("rst_a_ready", {31'd0, a_ready}, 0);
        chk("rst_rf_we", {31'd0, rf_we}, 0);
        chk("rst_rs1_busy", {31'd0, rs1_busy}, 0);
        nxt();
        rst = 0;
        mid();
        chk("post_rst_a_ready", {31'd0, a_ready}, 1);

        // lone A write, latency 1, single-cycle rf_we
        nxt();
        a_rd = 3; a_data = 32'hDEADBEEF;
        mid();
        chk("lone_a_ready", {31'd0, a_ready}, 1);
        nxt();
        a_valid = 0;
        mid();
        chk("lone_rf_we", {31'd0, rf_we}, 1);
        chk("lone_rf_rd", {27'd0, rf_rd}, 3);
        chk("lone_rf_wdata", rf_wdata, 32'hDEADBEEF);
        nxt();
        mid();
        chk("lone_rf_we_drop", {31'd0, rf_we}, 0);
        chk("lone_rf_wdata_hold", rf_wdata, 32'hDEADBEEF);

        // contention for four cycles from a fresh reset
        do_reset();
        a_valid = 1; a_rd = 1; a_data = 32'h11;
        b_valid = 1; b_rd = 2; b_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            mid();
`ifdef WB_ARB_RR_EN
            exp_a = (i % 2 == 0);
`else
            exp_a = 1'b1;
`endif
            chk("cont_a_ready", {31'd0, a_ready}, {31'd0, exp_a});
            chk("cont_b_ready", {31'd0, b_ready}, {31'd0, !exp_a});
            nxt();
        end
        idle_inputs();

        // scoreboard set, then cleared by a B write-back
        nxt();
        iss_valid = 1; iss_rd = 7;
        nxt();
        iss_valid = 0; rs1 = 7;
        mid();
        chk("sb_busy7", {31'd0, rs1_busy}, 1);
        nxt();
        b_valid = 1; b_rd = 7; b_data = 32'h77;
        mid();
        chk("sb_b_ready", {31'd0, b_ready}, 1);
        chk("sb_busy7_req", {31'd0, rs1_busy}, 1);
        nxt();
        b_valid = 0;
        mid();
        chk("sb_busy7_we", {31'd0, rs1_busy}, 1);
        nxt();
        mid();
        chk("sb_busy7_clear", {31'd0, rs1_busy}, 0);

        // set wins over simultaneous clear
        nxt();
        iss_valid = 1; iss_rd = 9; a_valid = 1; a_rd = 9; a_data = 32'h99;
        mid();
        chk("sw_a_ready", {31'd0, a_ready}, 1);
        nxt();
        iss_valid = 0; a_valid = 0; rs1 = 9;
        nxt();
        mid();
        chk("sw_busy9", {31'd0, rs1_busy}, 1);

        // rd==0 transfer, issue to x0
        nxt();
        a_valid = 1; a_rd = 0; a_data = 32'h1234;
        iss_valid = 1; iss_rd = 0; rs2 = 0;
        mid();
        chk("x0_a_ready", {31'd0, a_ready}, 1);
        nxt();
        a_valid = 0; iss_valid = 0;
        mid();
        chk("x0_rf_we", {31'd0, rf_we}, 0);
        chk("x0_rf_wdata", rf_wdata, 32'h1234);
        chk("x0_rs2_busy", {31'd0, rs2_busy}, 0);

        // reset arriving while a write sits in the output stage
        nxt();
        a_valid = 1; a_rd = 5; a_data = 32'h55;
        nxt();
        a_valid = 0; rst = 1;
        mid();
        chk("mid_rst_rf_we", {31'd0, rf_we}, 0);
        nxt();
        rst = 0;
        mid();
        chk("mid_rst_after_we", {31'd0, rf_we}, 0);

        // randomized traffic; requesters hold until accepted
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            a_took = a_valid && a_ready;
            b_took = b_valid && b_ready;
            nxt();
            if (!a_valid || a_took) begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_rd    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
                a_data  = $urandom;
            end
            if (!b_valid || b_took) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_rd    = 5'($urandom_range(0, 9));
                b_data  = $urandom;
            end
            iss_valid = $urandom_range(0, 1);
            iss_rd    = 5'($urandom_range(0, 9));
            rs1       = 5'($urandom_range(0, 9));
            rs2       = 5'($urandom_range(0, 9));
        end

        idle_inputs();
        nxt();
        mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: XLEN, 32, width of write-back data and register-file data port.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: a_valid  input  1  requester A (ALU write-back) holds a write.
REQ-005 Port: a_rd  input  5  requester A destination register.
REQ-006 Port: a_data  input  XLEN  requester A write data.
REQ-007 Port: a_ready  output  1  requester A write accepted this cycle.
REQ-008 Port: b_valid, b_rd, b_data, b_ready  as REQ-004..007  requester B (load unit write-back).
REQ-009 Port: iss_valid  input  1  an instruction with a destination register issues this cycle.
REQ-010 Port: iss_rd  input  5  destination register of the issuing instruction.
REQ-011 Port: rs1, rs2  input  5 each  source registers queried for hazards.
REQ-012 Port: rs1_busy, rs2_busy  output  1 each  queried register has a write pending.
REQ-013 Port: rf_we, rf_rd, rf_wdata  output  1/5/XLEN  register-file write port (we, rd, rd_data).

Function
REQ-014 Grant combinational: at most one of a_ready/b_ready high per cycle; ready is asserted only to a requester whose valid is high.
REQ-015 Transfer occurs when valid and ready are both high; requester holds valid, rd and data stable until transfer.
REQ-016 One transfer per cycle maximum; the output stage drains every cycle, so a lone valid requester is granted in the same cycle.
REQ-017 Transferred rd/data are registered into rf_rd/rf_wdata at the next rising edge; rf_we is 1 for exactly that one cycle (latency 1) when rd != 0.
REQ-018 Transfer with rd == 0: accepted (ready high), rf_we stays 0, rf_rd/rf_wdata still updated.
REQ-019 No transfer in a cycle: rf_we is 0 next cycle; rf_rd/rf_wdata hold their previous values.
REQ-020 Scoreboard: 32 busy bits; iss_valid with iss_rd != 0 sets busy[iss_rd] at the rising edge.
REQ-021 A transfer with rd != 0 clears busy[rd] at the same edge that loads the output stage.
REQ-022 Simultaneous set and clear of the same register: set wins (busy stays 1).
REQ-023 busy[0] is constant 0; issue to an already-busy register leaves it busy (no counting).
REQ-024 rsN_busy = busy[rsN] OR (rf_we AND rf_rd == rsN), forced 0 when rsN == 0, purely combinational.

Reset
REQ-025 While rst is high: rf_we=0, rf_rd=0, rf_wdata=0, all busy bits 0, a_ready=b_ready=0, round-robin pointer set to prefer A.
REQ-026 Reset asserted mid-transfer discards the captured write; no rf_we pulse follows reset deassertion.
REQ-027 First transfer possible in the first cycle after rst deasserts.

Configuration
REQ-028 Macro WB_ARB_RR_EN defined: round-robin; on contention the requester not granted most recently wins; pointer updates on every transfer.
REQ-029 Macro WB_ARB_RR_EN undefined: fixed priority, A always wins contention; pointer logic absent; B may starve.

Verification
REQ-030 Reset with a_valid=1: during rst a_ready=0, rf_we=0, rs1_busy=0 for rs1=5; first cycle after release a_ready=1.
REQ-031 a_valid=1,a_rd=3,a_data=0xDEADBEEF alone -> a_ready=1 same cycle; next cycle rf_we=1, rf_rd=3, rf_wdata=0xDEADBEEF; following cycle rf_we=0.
REQ-032 Both valid for 4 cycles (A rd=1, B rd=2): RR_EN -> grants A,B,A,B; without -> A,A,A,A with b_ready=0.
REQ-033 iss_valid,iss_rd=7 then rs1=7 -> rs1_busy=1; B writes rd=7 -> rs1_busy stays 1 during rf_we cycle, 0 the cycle after.
REQ-034 Same cycle iss_rd=9 and A transfer rd=9 -> busy[9] remains 1; a_rd=0 transfer -> a_ready=1, rf_we=0; iss_rd=0 -> rs2_busy for rs2=0 stays 0.
